// File: rtl/iter_compare_unit_if.sv
// Request/response bundle for iter_compare_unit: operand handshake in, flag handshake out.
// master = requester side, slave = compare unit.
interface iter_compare_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/iter_compare_unit.sv
// Multi-cycle set-on-compare unit: scans operands MSB-first, CHUNK bits per cycle.
// Optional macro CMP_EARLY_EXIT_EN finishes on the first differing chunk.
module iter_compare_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic clk,
  input  logic rst,
  iter_compare_unit_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic [2:0]       op_reg;
  logic             gt_reg;
  logic             lt_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] result_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;

  logic [CHUNK-1:0] top_a;
  logic [CHUNK-1:0] top_b;
  logic             locked;
  logic             gt_next;
  logic             lt_next;
  logic             last_chunk;
  logic             finish;
  logic             flag;
  logic             signed_mode;
  logic [WIDTH-1:0] msb_flip;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign signed_mode = (bus.op == 3'b000) || (bus.op == 3'b010) ||
                       (bus.op == 3'b110) || (bus.op == 3'b111);
  assign msb_flip    = {signed_mode, {(WIDTH-1){1'b0}}};

  assign top_a      = sa_reg[WIDTH-1 -: CHUNK];
  assign top_b      = sb_reg[WIDTH-1 -: CHUNK];
  assign locked     = gt_reg | lt_reg;
  assign gt_next    = locked ? gt_reg : (top_a > top_b);
  assign lt_next    = locked ? lt_reg : (top_a < top_b);
  assign last_chunk = (cnt_reg == CW'(N - 1));

`ifdef CMP_EARLY_EXIT_EN
  assign finish = last_chunk || gt_next || lt_next;
`else
  assign finish = last_chunk;
`endif

  always_comb begin
    flag = 1'b0;
    case (op_reg)
      3'b000, 3'b001: flag = lt_next;
      3'b010, 3'b011: flag = gt_next;
      3'b100:         flag = !gt_next && !lt_next;
      3'b101:         flag = gt_next || lt_next;
      3'b110:         flag = !gt_next;
      default:        flag = !lt_next;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      sa_reg        <= '0;
      sb_reg        <= '0;
      op_reg        <= '0;
      gt_reg        <= 1'b0;
      lt_reg        <= 1'b0;
      cnt_reg       <= '0;
      result_reg    <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            sa_reg       <= bus.a ^ msb_flip;
            sb_reg       <= bus.b ^ msb_flip;
            op_reg       <= bus.op;
            gt_reg       <= 1'b0;
            lt_reg       <= 1'b0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          gt_reg  <= gt_next;
          lt_reg  <= lt_next;
          sa_reg  <= sa_reg << CHUNK;
          sb_reg  <= sb_reg << CHUNK;
          cnt_reg <= cnt_reg + CW'(1);
          if (finish) begin
            result_reg    <= WIDTH'(flag);
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_iter_compare_unit.sv
// Randomized and directed bench for iter_compare_unit against an arithmetic reference model.
module tb_iter_compare_unit;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  iter_compare_unit_if #(.WIDTH(WIDTH)) bus ();

  iter_compare_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_flag(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic [2:0] op);
    case (op)
      3'd0:    return $signed(a) <  $signed(b);
      3'd1:    return a < b;
      3'd2:    return $signed(a) >  $signed(b);
      3'd3:    return a > b;
      3'd4:    return a == b;
      3'd5:    return a != b;
      3'd6:    return $signed(a) <= $signed(b);
      default: return $signed(a) >= $signed(b);
    endcase
  endfunction

  // Signed conditioning flips both MSBs, which never changes where operands first differ.
  function automatic int model_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef CMP_EARLY_EXIT_EN
    for (int j = 0; j < N; j++)
      if (a[WIDTH-1-j*CHUNK -: CHUNK] != b[WIDTH-1-j*CHUNK -: CHUNK]) return j + 1;
`endif
    return N;
  endfunction

  task automatic do_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] op, input bit exp_flag, input int hold,
                        input bit poke);
    int lat;
    logic [WIDTH-1:0] exp_res;
    exp_res = WIDTH'(exp_flag);
    @(negedge clk);
    check("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("busy_run", 64'(bus.busy), 64'd1);
    check("in_ready_run", 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_rise", 64'(bus.out_valid), 64'd1);
    check("latency", 64'(lat), 64'(model_lat(a, b)));
    check("result", 64'(bus.result), 64'(exp_res));
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bus.a = ~a; bus.b = b ^ 32'h5a5a_0001; bus.op = ~op; bus.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_result", 64'(bus.result), 64'(exp_res));
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_valid", 64'(bus.out_valid), 64'd0);
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    check("release_busy", 64'(bus.busy), 64'd0);
    $display("req op=%0d a=%08h b=%08h res=%0h exp=%0h lat=%0d hold=%0d",
             op, a, b, bus.result, exp_res, lat, hold);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [2:0] rop;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk); rst = 1'b0;

    do_req(32'd5,        32'hFFFF_FFFD, 3'd2, 1'b1, 0, 1'b0);
    do_req(32'hFFFF_FFFF, 32'd1,        3'd1, 1'b0, 0, 1'b0);
    do_req(32'hFFFF_FFFF, 32'd1,        3'd0, 1'b1, 0, 1'b0);
    do_req(32'h1234_5678, 32'h1234_5678, 3'd4, 1'b1, 0, 1'b0);
    do_req(32'h1234_5678, 32'h1234_5678, 3'd5, 1'b0, 0, 1'b0);
    do_req(32'h8000_0000, 32'd0,        3'd3, 1'b1, 0, 1'b0);
    do_req(32'h0000_0001, 32'h0000_0002, 3'd6, 1'b1, 3, 1'b1);
    do_req(32'h7FFF_FFFF, 32'h8000_0000, 3'd7, 1'b1, 0, 1'b0);

    // Abort on the second RUN cycle; last result above was 1, so the clear is visible.
    @(negedge clk);
    bus.a = 32'h0000_00FF; bus.b = 32'h0000_0000; bus.op = 3'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_result", 64'(bus.result), 64'd0);
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_busy", 64'(bus.busy), 64'd0);
    $display("abort mid-run: out_valid=%0d result=%0h in_ready=%0d",
             bus.out_valid, bus.result, bus.in_ready);
    @(negedge clk); rst = 1'b0;
    do_req(32'd0, 32'd0, 3'd7, 1'b1, 0, 1'b0);

    for (int t = 0; t < 150; t++) begin
      ra = $urandom;
      rb = $urandom;
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (32'h1 << $urandom_range(0, WIDTH - 1));
        2: rb = {ra[31:16], rb[15:0]};
        default: ;
      endcase
      do_req(ra, rb, rop, model_flag(ra, rb, rop), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
